div_ctrl: RTL and testbench
===========================

Name: div_ctrl

Overview:
Divide-op sequencer in the EXE stage. It accepts one div.w/mod.w/div.wu/mod.wu request from the pipeline and steers it to the signed or unsigned divider IP. It drives that IP's AXI-stream operand channels, collects the 64-bit dout and returns the quotient or remainder under a valid/ready handshake. Zero-divisor and signed-overflow cases are handled without issuing to the IP. A pipeline flush cancels the operation without ever violating the AXI-stream rule that tvalid, once asserted, stays up until accepted.

Parameters:
W, 32, operand/result width; IP dout width is 2*W.
QUOT_HI, 1, 1 = quotient in dout[2W-1:W] and remainder in dout[W-1:0]; 0 = swapped.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
flush  in  1  cancel the in-flight op (exception/branch)
req_valid  in  1  request present
req_ready  out  1  = (state==IDLE) & ~flush
req_op  in  2  00 div.w, 01 mod.w, 10 div.wu, 11 mod.wu
req_src1  in  W  dividend
req_src2  in  W  divisor
resp_valid  out  1  result available
resp_ready  in  1  pipeline consumes result
resp_result  out  W  quotient or remainder
ip_dividend  out  W  registered operand, shared by both IPs
ip_divisor  out  W  registered operand, shared by both IPs
sdiv_dividend_tvalid / udiv_dividend_tvalid  out  1 each
sdiv_dividend_tready / udiv_dividend_tready  in  1 each
sdiv_divisor_tvalid / udiv_divisor_tvalid  out  1 each
sdiv_divisor_tready / udiv_divisor_tready  in  1 each
sdiv_dout_tvalid / udiv_dout_tvalid  in  1 each
sdiv_dout_tdata / udiv_dout_tdata  in  2W each

Behaviour:
- Reset: state=IDLE; all tvalid=0; resp_valid=0; resp_result=0; ip_dividend=ip_divisor=0; cancel=0; is_signed=0; is_mod=0.
- States: IDLE, ISSUE, WAIT, RESP, DRAIN.
- IDLE: on req_valid&req_ready:
  - Latch the operands, is_signed=~req_op[1], is_mod=req_op[0].
  - If src2==0: go to RESP next cycle. Result is 0 for div, src1 for mod.
  - Else if signed and src1==0x80000000 and src2==0xFFFFFFFF: go to RESP. Result is 0x80000000 for div, 0 for mod.
  - Else go to ISSUE. Both tvalid of the selected IP rise on the next cycle; the other IP's tvalids stay 0.
- ISSUE: each channel is tracked independently. A channel's tvalid drops in the cycle after its tvalid&tready. Operands are held stable while any tvalid=1. When both channels have been accepted, go to WAIT, or to DRAIN if cancel=1.
- WAIT: on the selected IP's dout_tvalid, capture the result: is_mod selects the remainder field, otherwise the quotient field (per QUOT_HI). resp_valid=1 the next cycle, go to RESP. dout_tvalid from the unselected IP is ignored.
- RESP: hold resp_valid and resp_result until resp_ready=1, then go to IDLE with resp_valid=0. Minimum turnaround: new req accepted the cycle after the response handshake.
- Latency, IP path: accept at T, tvalid at T+1, resp_valid 1 cycle after dout_tvalid.
- Latency, bypass path: resp_valid at T+1.
- Flush handling:
  - IDLE: request ignored; req_ready=0 that cycle.
  - ISSUE: set cancel. Keep tvalids until accepted, then DRAIN.
  - WAIT: go to DRAIN.
  - RESP: resp_valid drops next cycle, go to IDLE.
  - DRAIN: wait for the selected dout_tvalid, discard it, go to IDLE with cancel=0. resp_valid is never raised.
  - A flush arriving while already in DRAIN has no further effect.
- Flush and dout_tvalid in the same cycle of WAIT: flush wins, the result is discarded, go to IDLE directly.
- Reset mid-operation returns to IDLE immediately. The IP is reset by the same reset signal, so no drain is needed.

Decomposition:
- Shared package div_pkg: op encodings (DIV_W, MOD_W, DIV_WU, MOD_WU), state encodings, INT_MIN constant.
- One sub-module div_ctrl_issue: a per-IP pair of channel-tracking valid flags with independent accept. It is instantiated twice (signed/unsigned), and its all_accepted output drives the FSM.

Test Plan:
- div.w 100/7, IP tready=1, dout_tvalid 8 cycles later with {14,2} -> resp_result=14, resp_valid exactly 1 cycle after dout_tvalid; only sdiv_* tvalids toggle.
- mod.wu 0xFFFFFFFF/16, dividend tready at +1, divisor tready at +4 -> dividend tvalid drops after +1, divisor tvalid stays high through +4; result 0xF.
- div.w 5/0 and mod.w 5/0 -> no tvalid ever asserted; resp_result 0 and 5 at T+1. div.w 0x80000000/-1 -> 0x80000000; mod.w -> 0.
- resp_ready held low 5 cycles -> resp_valid and resp_result stable; req_ready=0 throughout; new req accepted the cycle after the handshake.
- flush in ISSUE with divisor tready=0 -> divisor tvalid stays 1 until accepted, DRAIN, dout discarded, resp_valid never 1, req_ready=1 after dout_tvalid.
- flush in WAIT, then a new div.wu 9/2 after IDLE -> the first result is dropped, the second returns 4; reset mid-WAIT -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/div_pkg.sv
// Shared encodings for the EXE-stage divide sequencer: request opcodes,
// FSM state codes and the signed-overflow dividend.
package div_pkg;

    localparam logic [1:0] DIV_W  = 2'b00;
    localparam logic [1:0] MOD_W  = 2'b01;
    localparam logic [1:0] DIV_WU = 2'b10;
    localparam logic [1:0] MOD_WU = 2'b11;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ISSUE = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_RESP  = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;

    localparam logic [31:0] INT_MIN = 32'h8000_0000;

endpackage

// File: rtl/div_ctrl_issue.sv
// Operand-channel valid tracking for one divider IP: both tvalids rise on
// start and each drops independently the cycle after its own handshake.
module div_ctrl_issue (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic dividend_tready,
    input  logic divisor_tready,
    output logic dividend_tvalid,
    output logic divisor_tvalid,
    output logic all_accepted
);

    logic dvd_vld_q, dvd_vld_d;
    logic dvs_vld_q, dvs_vld_d;

    always_comb begin
        dvd_vld_d = dvd_vld_q & ~dividend_tready;
        dvs_vld_d = dvs_vld_q & ~divisor_tready;
        if (start) begin
            dvd_vld_d = 1'b1;
            dvs_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dvd_vld_q <= 1'b0;
            dvs_vld_q <= 1'b0;
        end else begin
            dvd_vld_q <= dvd_vld_d;
            dvs_vld_q <= dvs_vld_d;
        end
    end

    assign dividend_tvalid = dvd_vld_q;
    assign divisor_tvalid  = dvs_vld_q;
    // True when no channel will still be pending after this edge.
    assign all_accepted    = ~dvd_vld_d & ~dvs_vld_d;

endmodule

// File: rtl/div_ctrl.sv
// Divide-op sequencer: steers div/mod requests to the signed or unsigned
// divider IP, bypasses zero-divisor and overflow cases, and survives flushes.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | ready for a request
// ISSUE    | operand tvalids pending on the selected IP
// WAIT     | operands accepted, waiting for dout_tvalid
// RESP     | resp_valid held until resp_ready
// DRAIN    | cancelled op in flight; swallow its dout
module div_ctrl
    import div_pkg::*;
#(
    parameter int W       = 32,
    parameter bit QUOT_HI = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           flush,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [1:0]     req_op,
    input  logic [W-1:0]   req_src1,
    input  logic [W-1:0]   req_src2,
    output logic           resp_valid,
    input  logic           resp_ready,
    output logic [W-1:0]   resp_result,
    output logic [W-1:0]   ip_dividend,
    output logic [W-1:0]   ip_divisor,
    output logic           sdiv_dividend_tvalid,
    input  logic           sdiv_dividend_tready,
    output logic           sdiv_divisor_tvalid,
    input  logic           sdiv_divisor_tready,
    input  logic           sdiv_dout_tvalid,
    input  logic [2*W-1:0] sdiv_dout_tdata,
    output logic           udiv_dividend_tvalid,
    input  logic           udiv_dividend_tready,
    output logic           udiv_divisor_tvalid,
    input  logic           udiv_divisor_tready,
    input  logic           udiv_dout_tvalid,
    input  logic [2*W-1:0] udiv_dout_tdata
);

    localparam logic [W-1:0] MIN_NEG   = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] MINUS_ONE = '1;

    logic [2:0]     state_q, state_d;
    logic [W-1:0]   dvd_q, dvd_d, dvs_q, dvs_d, result_q, result_d;
    logic           resp_valid_q, resp_valid_d;
    logic           cancel_q, cancel_d;
    logic           is_signed_q, is_signed_d, is_mod_q, is_mod_d;
    logic           start_s, start_u, s_all, u_all, sel_all, sel_dout_vld;
    logic           accept, req_signed, req_mod;
    logic [2*W-1:0] sel_dout;
    logic [W-1:0]   quot, rem;

    assign req_ready    = (state_q == ST_IDLE) & ~flush;
    assign accept       = req_valid & req_ready;
    assign req_signed   = (req_op == DIV_W) | (req_op == MOD_W);
    assign req_mod      = (req_op == MOD_W) | (req_op == MOD_WU);
    assign sel_all      = is_signed_q ? s_all : u_all;
    assign sel_dout_vld = is_signed_q ? sdiv_dout_tvalid : udiv_dout_tvalid;
    assign sel_dout     = is_signed_q ? sdiv_dout_tdata : udiv_dout_tdata;
    assign quot         = QUOT_HI ? sel_dout[2*W-1:W] : sel_dout[W-1:0];
    assign rem          = QUOT_HI ? sel_dout[W-1:0] : sel_dout[2*W-1:W];

    always_comb begin
        state_d      = state_q;
        dvd_d        = dvd_q;
        dvs_d        = dvs_q;
        result_d     = result_q;
        resp_valid_d = resp_valid_q;
        cancel_d     = cancel_q;
        is_signed_d  = is_signed_q;
        is_mod_d     = is_mod_q;
        start_s      = 1'b0;
        start_u      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    dvd_d       = req_src1;
                    dvs_d       = req_src2;
                    is_signed_d = req_signed;
                    is_mod_d    = req_mod;
                    if (req_src2 == '0) begin
                        result_d     = req_mod ? req_src1 : '0;
                        resp_valid_d = 1'b1;
                        state_d      = ST_RESP;
                    end else if (req_signed && req_src1 == MIN_NEG && req_src2 == MINUS_ONE) begin
                        result_d     = req_mod ? '0 : MIN_NEG;
                        resp_valid_d = 1'b1;
                        state_d      = ST_RESP;
                    end else begin
                        start_s = req_signed;
                        start_u = ~req_signed;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                // A flush here cannot withdraw tvalid; remember it and drain later.
                if (flush) cancel_d = 1'b1;
                if (sel_all) state_d = (cancel_q | flush) ? ST_DRAIN : ST_WAIT;
            end
            ST_WAIT: begin
                if (flush) begin
                    state_d = sel_dout_vld ? ST_IDLE : ST_DRAIN;
                end else if (sel_dout_vld) begin
                    result_d     = is_mod_q ? rem : quot;
                    resp_valid_d = 1'b1;
                    state_d      = ST_RESP;
                end
            end
            ST_RESP: begin
                if (flush | resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (sel_dout_vld) begin
                    cancel_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            dvd_q        <= '0;
            dvs_q        <= '0;
            result_q     <= '0;
            resp_valid_q <= 1'b0;
            cancel_q     <= 1'b0;
            is_signed_q  <= 1'b0;
            is_mod_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            dvd_q        <= dvd_d;
            dvs_q        <= dvs_d;
            result_q     <= result_d;
            resp_valid_q <= resp_valid_d;
            cancel_q     <= cancel_d;
            is_signed_q  <= is_signed_d;
            is_mod_q     <= is_mod_d;
        end
    end

    div_ctrl_issue u_issue_s (
        .clk             (clk),
        .reset           (reset),
        .start           (start_s),
        .dividend_tready (sdiv_dividend_tready),
        .divisor_tready  (sdiv_divisor_tready),
        .dividend_tvalid (sdiv_dividend_tvalid),
        .divisor_tvalid  (sdiv_divisor_tvalid),
        .all_accepted    (s_all)
    );

    div_ctrl_issue u_issue_u (
        .clk             (clk),
        .reset           (reset),
        .start           (start_u),
        .dividend_tready (udiv_dividend_tready),
        .divisor_tready  (udiv_divisor_tready),
        .dividend_tvalid (udiv_dividend_tvalid),
        .divisor_tvalid  (udiv_divisor_tvalid),
        .all_accepted    (u_all)
    );

    assign resp_valid  = resp_valid_q;
    assign resp_result = result_q;
    assign ip_dividend = dvd_q;
    assign ip_divisor  = dvs_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: an arithmetic reference model plus a per-cycle
// expectation set, compared against the DUT on every falling edge.
module tb_div_ctrl;
    import div_pkg::*;

    logic        clk = 1'b0;
    logic        reset, flush, req_valid, req_ready, resp_valid, resp_ready;
    logic [1:0]  req_op;
    logic [31:0] req_src1, req_src2, resp_result, ip_dividend, ip_divisor;
    logic        s_dvd_v, s_dvd_r, s_dvs_v, s_dvs_r, s_dout_v;
    logic        u_dvd_v, u_dvd_r, u_dvs_v, u_dvs_r, u_dout_v;
    logic [63:0] s_dout, u_dout;

    int n_tests = 0;
    int n_fail  = 0;

    logic        chk_en = 1'b0;
    logic        exp_req_ready, exp_resp_valid;
    logic [31:0] exp_result, exp_dvd, exp_dvs;
    logic [3:0]  exp_tv;   // {s_dvd, s_dvs, u_dvd, u_dvs}

    div_ctrl #(.W(32), .QUOT_HI(1'b1)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_src1(req_src1), .req_src2(req_src2),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
        .ip_dividend(ip_dividend), .ip_divisor(ip_divisor),
        .sdiv_dividend_tvalid(s_dvd_v), .sdiv_dividend_tready(s_dvd_r),
        .sdiv_divisor_tvalid(s_dvs_v), .sdiv_divisor_tready(s_dvs_r),
        .sdiv_dout_tvalid(s_dout_v), .sdiv_dout_tdata(s_dout),
        .udiv_dividend_tvalid(u_dvd_v), .udiv_dividend_tready(u_dvd_r),
        .udiv_divisor_tvalid(u_dvs_v), .udiv_divisor_tready(u_dvs_r),
        .udiv_dout_tvalid(u_dout_v), .udiv_dout_tdata(u_dout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result of a request, including the bypass cases.
    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        logic sgn, md;
        sgn = (op == DIV_W) || (op == MOD_W);
        md  = (op == MOD_W) || (op == MOD_WU);
        if (b == 0) return md ? a : 32'd0;
        if (sgn && a == INT_MIN && b == 32'hFFFF_FFFF) return md ? 32'd0 : INT_MIN;
        if (sgn) begin
            sa = a;
            sb = b;
            return md ? 32'(sa % sb) : 32'(sa / sb);
        end
        return md ? a % b : a / b;
    endfunction

    // What a divider IP would return: {quotient, remainder}.
    function automatic logic [63:0] ip_dout(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        if (op == DIV_W || op == MOD_W) return {32'(sa / sb), 32'(sa % sb)};
        return {a / b, a % b};
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready", req_ready, exp_req_ready);
            chk("resp_valid", resp_valid, exp_resp_valid);
            if (exp_resp_valid) chk("resp_result", resp_result, exp_result);
            chk("sdiv_dividend_tvalid", s_dvd_v, exp_tv[3]);
            chk("sdiv_divisor_tvalid", s_dvs_v, exp_tv[2]);
            chk("udiv_dividend_tvalid", u_dvd_v, exp_tv[1]);
            chk("udiv_divisor_tvalid", u_dvs_v, exp_tv[0]);
            if (|exp_tv) begin
                chk("ip_dividend", ip_dividend, exp_dvd);
                chk("ip_divisor", ip_divisor, exp_dvs);
            end
        end
    end

    // Advance one cycle; inputs return to idle and expectations to "busy, nothing valid".
    task automatic nxt();
        @(posedge clk);
        #1;
        reset = 1'b0; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
        s_dvd_r = 1'b0; s_dvs_r = 1'b0; s_dout_v = 1'b0;
        u_dvd_r = 1'b0; u_dvs_r = 1'b0; u_dout_v = 1'b0;
        exp_req_ready = 1'b0; exp_resp_valid = 1'b0; exp_tv = 4'b0;
    endtask

    task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        nxt();
        req_valid = 1'b1; req_op = op; req_src1 = a; req_src2 = b;
        exp_req_ready = 1'b1;
        exp_dvd = a; exp_dvs = b;
    endtask

    // IP-path op: tready pulses at cycles dvd_acc/dvs_acc after accept, dout
    // dout_dly cycles after the last acceptance, resp_ready held low for hold cycles.
    task automatic ip_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int dvd_acc, input int dvs_acc, input int dout_dly,
                         input int hold, input logic [31:0] lit);
        logic sgn;
        int   acc, kd, kr;
        sgn = (op == DIV_W) || (op == MOD_W);
        acc = (dvd_acc > dvs_acc) ? dvd_acc : dvs_acc;
        kd  = acc + dout_dly;
        kr  = kd + 1;
        send(op, a, b);
        for (int k = 1; k <= kr + hold; k++) begin
            nxt();
            if (sgn) begin
                exp_tv[3:2] = {k <= dvd_acc, k <= dvs_acc};
                s_dvd_r = (k == dvd_acc);
                s_dvs_r = (k == dvs_acc);
            end else begin
                exp_tv[1:0] = {k <= dvd_acc, k <= dvs_acc};
                u_dvd_r = (k == dvd_acc);
                u_dvs_r = (k == dvs_acc);
            end
            if (k == acc + 1 && dout_dly >= 2) begin
                if (sgn) begin u_dout_v = 1'b1; u_dout = 64'hDEAD_BEEF_CAFE_F00D; end
                else begin s_dout_v = 1'b1; s_dout = 64'hDEAD_BEEF_CAFE_F00D; end
            end
            if (k == kd) begin
                if (sgn) begin s_dout_v = 1'b1; s_dout = ip_dout(op, a, b); end
                else begin u_dout_v = 1'b1; u_dout = ip_dout(op, a, b); end
            end
            if (k >= kr) begin
                exp_resp_valid = 1'b1;
                exp_result     = ref_result(op, a, b);
                resp_ready     = (k == kr + hold);
            end
            if (k == kr) chk("literal_result", resp_result, lit);
        end
    endtask

    task automatic byp_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] lit);
        send(op, a, b);
        nxt();
        exp_resp_valid = 1'b1;
        exp_result     = ref_result(op, a, b);
        resp_ready     = 1'b1;
        chk("bypass_literal", resp_result, lit);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
        req_op = 2'b0; req_src1 = '0; req_src2 = '0;
        s_dvd_r = 1'b0; s_dvs_r = 1'b0; s_dout_v = 1'b0; s_dout = '0;
        u_dvd_r = 1'b0; u_dvs_r = 1'b0; u_dout_v = 1'b0; u_dout = '0;
        exp_req_ready = 1'b1; exp_resp_valid = 1'b0; exp_tv = 4'b0;
        exp_result = '0; exp_dvd = '0; exp_dvs = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_resp_valid", resp_valid, 1'b0);
        chk("reset_resp_result", resp_result, 32'd0);
        chk("reset_ip_operands", {ip_dividend, ip_divisor}, 64'd0);
        chk("reset_tvalids", {s_dvd_v, s_dvs_v, u_dvd_v, u_dvs_v}, 4'b0);
        chk("reset_req_ready", req_ready, 1'b1);
        chk_en = 1'b1;

        ip_op(DIV_W, 32'd100, 32'd7, 1, 1, 7, 0, 32'd14);
        ip_op(MOD_WU, 32'hFFFF_FFFF, 32'd16, 1, 4, 3, 0, 32'hF);
        byp_op(DIV_W, 32'd5, 32'd0, 32'd0);
        byp_op(MOD_W, 32'd5, 32'd0, 32'd5);
        byp_op(DIV_W, INT_MIN, 32'hFFFF_FFFF, INT_MIN);
        byp_op(MOD_W, INT_MIN, 32'hFFFF_FFFF, 32'd0);
        ip_op(DIV_WU, INT_MIN, 32'hFFFF_FFFF, 1, 1, 2, 0, 32'd0);
        ip_op(DIV_W, 32'hFFFF_FF9C, 32'd7, 2, 1, 2, 5, 32'hFFFF_FFF2);
        ip_op(MOD_W, 32'hFFFF_FF9C, 32'd7, 3, 3, 1, 0, 32'hFFFF_FFFE);

        // flush while the divisor channel is still pending, again in DRAIN
        send(DIV_W, 32'd50, 32'd5);
        nxt(); exp_tv[3:2] = 2'b11; s_dvd_r = 1'b1; flush = 1'b1;
        nxt(); exp_tv[3:2] = 2'b01;
        nxt(); exp_tv[3:2] = 2'b01; s_dvs_r = 1'b1;
        nxt(); flush = 1'b1;
        nxt(); s_dout_v = 1'b1; s_dout = ip_dout(DIV_W, 32'd50, 32'd5);
        nxt(); exp_req_ready = 1'b1;

        // flush in WAIT, then a fresh unsigned divide
        send(DIV_W, 32'd100, 32'd7);
        nxt(); exp_tv[3:2] = 2'b11; s_dvd_r = 1'b1; s_dvs_r = 1'b1;
        nxt(); flush = 1'b1;
        nxt();
        nxt(); s_dout_v = 1'b1; s_dout = ip_dout(DIV_W, 32'd100, 32'd7);
        nxt(); exp_req_ready = 1'b1;
        ip_op(DIV_WU, 32'd9, 32'd2, 1, 1, 3, 0, 32'd4);

        // flush and dout in the same WAIT cycle go straight to IDLE
        send(MOD_W, 32'd17, 32'd5);
        nxt(); exp_tv[3:2] = 2'b11; s_dvd_r = 1'b1; s_dvs_r = 1'b1;
        nxt(); flush = 1'b1; s_dout_v = 1'b1; s_dout = ip_dout(MOD_W, 32'd17, 32'd5);
        nxt(); exp_req_ready = 1'b1;

        // flush while the response is pending
        send(MOD_W, 32'd9, 32'd0);
        nxt(); exp_resp_valid = 1'b1; exp_result = 32'd9; flush = 1'b1;
        nxt(); exp_req_ready = 1'b1;

        // flush in IDLE ignores the request
        nxt(); req_valid = 1'b1; req_op = MOD_W; req_src1 = 32'd3; req_src2 = 32'd0; flush = 1'b1;
        nxt(); exp_req_ready = 1'b1;
        nxt(); exp_req_ready = 1'b1;

        ip_op(DIV_WU, 32'd9, 32'd2, 1, 1, 2, 0, 32'd4);

        // reset in WAIT returns everything to reset values next cycle
        send(DIV_WU, 32'd77, 32'd3);
        nxt(); exp_tv[1:0] = 2'b11; u_dvd_r = 1'b1; u_dvs_r = 1'b1;
        nxt(); reset = 1'b1;
        nxt(); exp_req_ready = 1'b1;
        chk("midreset_result", resp_result, 32'd0);
        chk("midreset_operands", {ip_dividend, ip_divisor}, 64'd0);
        nxt(); exp_req_ready = 1'b1;
        u_dout_v = 1'b1; u_dout = ip_dout(DIV_WU, 32'd77, 32'd3);

        ip_op(MOD_WU, 32'd1000, 32'd33, 1, 2, 2, 1, 32'd10);

        nxt();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
